// File: rtl/signed_pow2_divide_pipelined.sv
// Pipelined signed divide by 2^s: bias stage followed by one log-shift stage per shift bit.
// Optional remainder output enabled by defining SIGNED_POW2_DIVIDE_REMAINDER_EN.
module signed_pow2_divide_pipelined #(
    parameter int N  = 8,
    parameter int SW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_a,
    input  logic [SW-1:0] in_s,
    input  logic          in_mode,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_q
`ifdef SIGNED_POW2_DIVIDE_REMAINDER_EN
    ,
    output logic [N-1:0]  out_r
`endif
);

    localparam logic [SW-1:0] S_MAX = SW'(N - 1);

    logic [SW:0]         v_reg;
    logic [SW:0]         rdy;
    logic signed [N-1:0] d_reg   [0:SW];
    logic [SW-1:0]       s_reg   [0:SW-1];
    logic signed [N-1:0] sh_next [1:SW];

    logic [SW-1:0]       s_sat;
    logic [N-1:0]        low_mask;
    logic [N-1:0]        bias;
    logic signed [N-1:0] a_biased;

    // Negative dividends in truncate mode get 2^s-1 added so the floor shift rounds toward zero.
    always_comb begin
        s_sat    = (in_s > S_MAX) ? S_MAX : in_s;
        low_mask = (N'(1) << s_sat) - N'(1);
        bias     = (in_mode && in_a[N-1]) ? low_mask : '0;
        a_biased = $signed(in_a + bias);
    end

`ifdef SIGNED_POW2_DIVIDE_REMAINDER_EN
    logic [N-1:0] r_reg [0:SW];
    logic [N-1:0] low_bits;
    logic [N-1:0] r_first;

    // Truncate remainder of a negative dividend is the floor remainder minus 2^s (unless zero).
    always_comb begin
        low_bits = in_a & low_mask;
        r_first  = low_bits;
        if (in_mode && in_a[N-1] && (low_bits != '0)) begin
            r_first = low_bits - (N'(1) << s_sat);
        end
    end
`endif

    genvar gi;

    // A stage can load when it, or any stage after it, has room or the output drains.
    generate
        for (gi = 0; gi <= SW; gi++) begin : g_ready
            assign rdy[gi] = out_ready || !(&v_reg[SW:gi]);
        end
        for (gi = 1; gi <= SW; gi++) begin : g_shift
            assign sh_next[gi] = s_reg[gi-1][gi-1] ? (d_reg[gi-1] >>> (1 << (gi - 1)))
                                                  : d_reg[gi-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_reg <= '0;
            for (int k = 0; k <= SW; k++) begin
                d_reg[k] <= '0;
`ifdef SIGNED_POW2_DIVIDE_REMAINDER_EN
                r_reg[k] <= '0;
`endif
            end
            for (int k = 0; k < SW; k++) begin
                s_reg[k] <= '0;
            end
        end else begin
            if (rdy[0]) begin
                v_reg[0] <= in_valid;
                if (in_valid) begin
                    d_reg[0] <= a_biased;
                    s_reg[0] <= s_sat;
`ifdef SIGNED_POW2_DIVIDE_REMAINDER_EN
                    r_reg[0] <= r_first;
`endif
                end
            end
            for (int k = 1; k <= SW; k++) begin
                if (rdy[k]) begin
                    v_reg[k] <= v_reg[k-1];
                    if (v_reg[k-1]) begin
                        d_reg[k] <= sh_next[k];
`ifdef SIGNED_POW2_DIVIDE_REMAINDER_EN
                        r_reg[k] <= r_reg[k-1];
`endif
                    end
                end
            end
            for (int k = 1; k < SW; k++) begin
                if (rdy[k] && v_reg[k-1]) begin
                    s_reg[k] <= s_reg[k-1];
                end
            end
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = v_reg[SW];
    assign out_q     = d_reg[SW];
`ifdef SIGNED_POW2_DIVIDE_REMAINDER_EN
    assign out_r     = r_reg[SW];
`endif

endmodule
